// File: rtl/sincos_pkg.sv
// Shared types, constants and helpers for the sine/cosine pipeline.
package sincos_pkg;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quadrant_e;

  localparam int LUT_DEPTH = 91;
  localparam int ANGLE_MAX = 360;
  localparam int IDX_W     = 7;

  // Full-scale code (+1.0) for a signed output of amp_w bits.
  function automatic int full_scale(input int amp_w);
    return 1 << (amp_w - 2);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine ROM, 91 entries (0..90 degrees), synchronous 1-cycle read.
// The second read port exists only when SINCOS_COS_EN is defined.
module quarter_sine_rom
  import sincos_pkg::*;
#(
  parameter int AMP_W = 18
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_addr_a,
  output logic [AMP_W-1:0] o_data_a
`ifdef SINCOS_COS_EN
  ,
  input  logic [IDX_W-1:0] i_addr_b,
  output logic [AMP_W-1:0] o_data_b
`endif
);

  // Entry 90 is pinned to full scale so the peak never depends on rounding.
  function automatic logic [AMP_W-1:0] sine_entry(input int k);
    real v;
    if (k == LUT_DEPTH - 1) return AMP_W'(full_scale(AMP_W));
    v = $sin(real'(k) * 3.14159265358979323846 / 180.0) * real'(full_scale(AMP_W));
    return AMP_W'($rtoi(v + 0.5));
  endfunction

  logic [AMP_W-1:0] w_rom [LUT_DEPTH];
  logic [AMP_W-1:0] r_data_a;

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    assign w_rom[k] = sine_entry(k);
  end

  // Port A read, held while the pipeline is stalled.
  always_ff @(posedge i_clk) begin
    if (i_en) r_data_a <= w_rom[i_addr_a];
  end

  assign o_data_a = r_data_a;

`ifdef SINCOS_COS_EN
  logic [AMP_W-1:0] r_data_b;

  // Port B read for the cosine path.
  always_ff @(posedge i_clk) begin
    if (i_en) r_data_b <= w_rom[i_addr_b];
  end

  assign o_data_b = r_data_b;
`endif

endmodule

// File: rtl/sincos_pipe.sv
// Three-stage sine/cosine pipeline: S1 fold, S2 ROM read, S3 sign apply.
// Define SINCOS_COS_EN to build the cosine path; otherwise cos_out is 0.
module sincos_pipe
  import sincos_pkg::*;
#(
  parameter int ANGLE_W = 9,
  parameter int AMP_W   = 18,
  parameter int TAG_W   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [ANGLE_W-1:0]      angle_in,
  input  logic [TAG_W-1:0]        tag_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [AMP_W-1:0] sin_out,
  output logic signed [AMP_W-1:0] cos_out,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    err_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [ANGLE_W-1:0] A90  = ANGLE_W'(90);
  localparam logic [ANGLE_W-1:0] A180 = ANGLE_W'(180);
  localparam logic [ANGLE_W-1:0] A270 = ANGLE_W'(270);
  localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);

  logic             w_adv;
  quadrant_e        w_quad;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_sin_neg;
  logic [AMP_W-1:0] w_sin_mag;

  logic             r_s1_valid, r_s1_sin_neg, r_s1_err;
  logic [IDX_W-1:0] r_s1_idx;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid, r_s2_sin_neg, r_s2_err;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_out_valid, r_err;
  logic [AMP_W-1:0] r_sin;
  logic [TAG_W-1:0] r_tag;

  // The whole pipeline moves together; any empty or draining output frees it.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Fold the angle onto the quarter wave; out-of-range angles read index 0.
  always_comb begin
    w_quad = Q0;
    w_idx  = '0;
    w_err  = (angle_in >= AMAX);
    if (angle_in < A90) begin
      w_quad = Q0;
      w_idx  = IDX_W'(angle_in);
    end else if (angle_in < A180) begin
      w_quad = Q1;
      w_idx  = IDX_W'(A180 - angle_in);
    end else if (angle_in < A270) begin
      w_quad = Q2;
      w_idx  = IDX_W'(angle_in - A180);
    end else if (!w_err) begin
      w_quad = Q3;
      w_idx  = IDX_W'(AMAX - angle_in);
    end
    w_sin_neg = (w_quad == Q2) || (w_quad == Q3);
  end

  // S1 and S2 control/side-band registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid   <= 1'b0;
      r_s1_sin_neg <= 1'b0;
      r_s1_err     <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_sin_neg <= 1'b0;
      r_s2_err     <= 1'b0;
      r_s2_tag     <= '0;
    end else if (w_adv) begin
      r_s1_valid   <= in_valid;
      r_s1_sin_neg <= w_sin_neg;
      r_s1_err     <= w_err;
      r_s1_idx     <= w_idx;
      r_s1_tag     <= tag_in;
      r_s2_valid   <= r_s1_valid;
      r_s2_sin_neg <= r_s1_sin_neg;
      r_s2_err     <= r_s1_err;
      r_s2_tag     <= r_s1_tag;
    end
  end

  // S3 output registers; results only load when a valid sample arrives.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_out_valid <= 1'b0;
      r_sin       <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_tag <= r_s2_tag;
        r_err <= r_s2_err;
        if (r_s2_err)          r_sin <= '0;
        else if (r_s2_sin_neg) r_sin <= AMP_W'(0) - w_sin_mag;
        else                   r_sin <= w_sin_mag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sin_out   = r_sin;
  assign tag_out   = r_tag;
  assign err_out   = r_err;

`ifdef SINCOS_COS_EN
  logic             w_cos_neg;
  logic [IDX_W-1:0] w_cos_idx;
  logic [AMP_W-1:0] w_cos_mag;
  logic             r_s1_cos_neg, r_s2_cos_neg;
  logic [AMP_W-1:0] r_cos;

  assign w_cos_neg = (angle_in > A90) && (angle_in < A270);
  assign w_cos_idx = IDX_W'(LUT_DEPTH - 1) - r_s1_idx;

  // Cosine sign travels beside the sine sign; magnitude comes from port B.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_cos_neg <= 1'b0;
      r_s2_cos_neg <= 1'b0;
      r_cos        <= '0;
    end else if (w_adv) begin
      r_s1_cos_neg <= w_cos_neg;
      r_s2_cos_neg <= r_s1_cos_neg;
      if (r_s2_valid) begin
        if (r_s2_err)          r_cos <= '0;
        else if (r_s2_cos_neg) r_cos <= AMP_W'(0) - w_cos_mag;
        else                   r_cos <= w_cos_mag;
      end
    end
  end

  assign cos_out = r_cos;

  quarter_sine_rom #(.AMP_W(AMP_W)) u_rom (
    .i_clk    (clk_in),
    .i_en     (w_adv),
    .i_addr_a (r_s1_idx),
    .o_data_a (w_sin_mag),
    .i_addr_b (w_cos_idx),
    .o_data_b (w_cos_mag)
  );
`else
  assign cos_out = '0;

  quarter_sine_rom #(.AMP_W(AMP_W)) u_rom (
    .i_clk    (clk_in),
    .i_en     (w_adv),
    .i_addr_a (r_s1_idx),
    .o_data_a (w_sin_mag)
  );
`endif

endmodule

// File: tb/tb_sincos_pipe.sv
// Self-checking bench for sincos_pipe (ANGLE_W=9, AMP_W=18, TAG_W=4).
// Expected cosine follows SINCOS_COS_EN: real cosine when defined, else 0.
module tb_sincos_pipe;

  localparam int  ANGLE_W = 9;
  localparam int  AMP_W   = 18;
  localparam int  TAG_W   = 4;
  localparam real PI      = 3.14159265358979323846;
  localparam real FS      = 65536.0;
`ifdef SINCOS_COS_EN
  localparam bit  COS_EN  = 1'b1;
`else
  localparam bit  COS_EN  = 1'b0;
`endif

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b1;
  logic [ANGLE_W-1:0]      angle_in = '0;
  logic [TAG_W-1:0]        tag_in = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [AMP_W-1:0] sin_out;
  logic signed [AMP_W-1:0] cos_out;
  logic [TAG_W-1:0]        tag_out;
  logic                    err_out;
  logic                    out_valid;
  logic                    out_ready = 1'b1;

  sincos_pipe #(.ANGLE_W(ANGLE_W), .AMP_W(AMP_W), .TAG_W(TAG_W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .angle_in  (angle_in),
    .tag_in    (tag_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .tag_out   (tag_out),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int s;
    int c;
    int tag;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rx = 0;
  int   ang[64];
  int   tg[64];

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", name, got, want);
  endtask

  function automatic int rnd(input real v);
    if (v < 0.0) return -$rtoi(-v + 0.5);
    return $rtoi(v + 0.5);
  endfunction

  // Reference: direct trigonometry on the unfolded angle.
  function automatic exp_t model(input int a, input int t);
    exp_t e;
    e.tag = t;
    e.err = (a >= 360) ? 1 : 0;
    e.s = 0;
    e.c = 0;
    if (a < 360) begin
      e.s = rnd(FS * $sin(real'(a) * PI / 180.0));
      if (COS_EN) e.c = rnd(FS * $cos(real'(a) * PI / 180.0));
    end
    return e;
  endfunction

  // Monitor: scoreboard on each transfer, hold check across stalls.
  logic                    hold_pend = 1'b0;
  logic signed [AMP_W-1:0] h_sin, h_cos;
  logic [TAG_W-1:0]        h_tag;
  logic                    h_err;
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      hold_pend = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_sin", 32'(sin_out), 32'(h_sin));
        chk("hold_cos", 32'(cos_out), 32'(h_cos));
        chk("hold_tag", 32'(tag_out), 32'(h_tag));
        chk("hold_err", 32'(err_out), 32'(h_err));
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_sin", 32'(sin_out), e.s);
          chk("sb_cos", 32'(cos_out), e.c);
          chk("sb_tag", 32'(tag_out), e.tag);
          chk("sb_err", 32'(err_out), e.err);
          n_rx++;
        end
      end
      hold_pend = out_valid && !out_ready;
      h_sin = sin_out;
      h_cos = cos_out;
      h_tag = tag_out;
      h_err = err_out;
    end
  end

  // One clock of stimulus, entered and left just after a rising edge.
  task automatic cycle(input bit v, input int a, input int t, input bit ordy,
                       output bit acc);
    in_valid  = v;
    angle_in  = ANGLE_W'(a);
    tag_in    = TAG_W'(t);
    out_ready = ordy;
    @(negedge clk_in);
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(a, t));
    @(posedge clk_in);
    #1;
  endtask

  task automatic stream(input int n, input int st_lo, input int st_hi,
                        input bit rnd_rdy);
    int sent = 0;
    int cyc = 0;
    bit acc, r;
    while (sent < n && cyc < 400) begin
      r = rnd_rdy ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc < st_hi);
      cycle(1'b1, ang[sent], tg[sent], r, acc);
      if (!rnd_rdy && !r) chk("stall_no_accept", 32'(acc), 0);
      if (acc) sent++;
      cyc++;
    end
    chk("stream_sent", sent, n);
  endtask

  task automatic drain();
    int cyc = 0;
    bit acc;
    while (exp_q.size() != 0 && cyc < 50) begin
      cycle(1'b0, 0, 0, 1'b1, acc);
      cyc++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int rx0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_in    = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Reset state
    @(negedge clk_in);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sin", 32'(sin_out), 0);
    chk("rst_tag", 32'(tag_out), 0);
    @(posedge clk_in);
    #1;

    // Angle 30, tag 3: latency 3
    cycle(1'b1, 30, 3, 1'b1, acc);
    chk("acc30", 32'(acc), 1);
    in_valid = 1'b0;
    @(negedge clk_in);
    chk("lat_c1", 32'(out_valid), 0);
    @(negedge clk_in);
    chk("lat_c2", 32'(out_valid), 0);
    @(negedge clk_in);
    chk("lat_c3", 32'(out_valid), 1);
    chk("a30_sin", 32'(sin_out), 32768);
    chk("a30_cos", 32'(cos_out), COS_EN ? 56756 : 0);
    chk("a30_tag", 32'(tag_out), 3);
    chk("a30_err", 32'(err_out), 0);
    @(posedge clk_in);
    #1;

    // 90, 180, 270 back to back
    cycle(1'b1, 90, 1, 1'b1, acc);
    cycle(1'b1, 180, 2, 1'b1, acc);
    cycle(1'b1, 270, 4, 1'b1, acc);
    in_valid = 1'b0;
    @(negedge clk_in);
    chk("b2b90_sin", 32'(sin_out), 65536);
    chk("b2b90_cos", 32'(cos_out), 0);
    chk("b2b90_v", 32'(out_valid), 1);
    @(negedge clk_in);
    chk("b2b180_sin", 32'(sin_out), 0);
    chk("b2b180_cos", 32'(cos_out), COS_EN ? -65536 : 0);
    chk("b2b180_v", 32'(out_valid), 1);
    @(negedge clk_in);
    chk("b2b270_sin", 32'(sin_out), -65536);
    chk("b2b270_cos", 32'(cos_out), 0);
    chk("b2b270_v", 32'(out_valid), 1);
    @(posedge clk_in);
    #1;

    // Angle 210
    cycle(1'b1, 210, 6, 1'b1, acc);
    in_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("a210_sin", 32'(sin_out), -32768);
    chk("a210_cos", 32'(cos_out), COS_EN ? -56756 : 0);
    @(posedge clk_in);
    #1;

    // Out-of-range angles 360 and 511
    cycle(1'b1, 360, 5, 1'b1, acc);
    cycle(1'b1, 511, 9, 1'b1, acc);
    in_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("a360_err", 32'(err_out), 1);
    chk("a360_sin", 32'(sin_out), 0);
    chk("a360_cos", 32'(cos_out), 0);
    chk("a360_tag", 32'(tag_out), 5);
    @(negedge clk_in);
    chk("a511_err", 32'(err_out), 1);
    chk("a511_sin", 32'(sin_out), 0);
    chk("a511_cos", 32'(cos_out), 0);
    chk("a511_tag", 32'(tag_out), 9);
    @(posedge clk_in);
    #1;
    drain();

    // Ten-sample stream with a 4-cycle consumer stall
    for (int i = 0; i < 10; i++) begin
      ang[i] = (i * 37 + 11) % 360;
      tg[i]  = i;
    end
    rx0 = n_rx;
    stream(10, 4, 8, 1'b0);
    drain();
    chk("stream10_rx", n_rx - rx0, 10);

    // Reset with two samples in flight
    cycle(1'b1, 45, 1, 1'b1, acc);
    cycle(1'b1, 100, 2, 1'b1, acc);
    in_valid = 1'b0;
    rst_in   = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_sin", 32'(sin_out), 0);
    chk("post_rst_cos", 32'(cos_out), 0);
    chk("post_rst_tag", 32'(tag_out), 0);
    chk("post_rst_err", 32'(err_out), 0);
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_no_valid", 32'(out_valid), 0);
      @(negedge clk_in);
    end
    @(posedge clk_in);
    #1;
    rx0 = n_rx;
    cycle(1'b1, 60, 7, 1'b1, acc);
    drain();
    chk("post_rst_new_rx", n_rx - rx0, 1);

    // Randomised angles (including out-of-range) with random back-pressure
    for (int i = 0; i < 40; i++) begin
      ang[i] = $urandom_range(0, 511);
      tg[i]  = $urandom_range(0, 15);
    end
    rx0 = n_rx;
    stream(40, 0, 0, 1'b1);
    drain();
    chk("random_rx", n_rx - rx0, 40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sincos_pipe.md
SINCOS_PIPE -- requirements
Module: sincos_pipe

Interface
REQ-001 The block SHALL have parameter ANGLE_W, default 9, giving the unsigned angle input width in whole degrees; legal values are 9 or more.
REQ-002 The block SHALL have parameter AMP_W, default 18, giving the signed two's-complement output width; full scale +1.0 = 2^(AMP_W-2).
REQ-003 The block SHALL have parameter TAG_W, default 4, giving the width of the caller tag (channel id) carried alongside each sample.
REQ-004 The block SHALL have port clk_in, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit, the reset: synchronous, active-high.
REQ-006 The block SHALL have port angle_in, input, ANGLE_W bits, the angle in degrees.
REQ-007 The block SHALL have port tag_in, input, TAG_W bits, the caller tag.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the input is presented.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the input this cycle.
REQ-010 The block SHALL have port sin_out, output, AMP_W bits, signed sine.
REQ-011 The block SHALL have port cos_out, output, AMP_W bits, signed cosine.
REQ-012 The block SHALL have port tag_out, output, TAG_W bits, the tag of the result.
REQ-013 The block SHALL have port err_out, output, 1 bit, meaning angle_in was 360 or more.
REQ-014 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-015 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.

Function
REQ-016 An input SHALL be accepted on a cycle where in_valid && in_ready, and a result SHALL be transferred on a cycle where out_valid && out_ready.
REQ-017 The block SHALL be a 3-stage pipeline (S1 fold, S2 ROM read, S3 sign apply) with a latency of exactly 3 cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-018 The pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-019 While adv = 0, every stage, its valid bit and sin_out/cos_out/tag_out/err_out SHALL hold, and nothing SHALL be dropped or duplicated.
REQ-020 Full throughput SHALL be one result per cycle while out_ready = 1.
REQ-021 S1 SHALL fold the angle a to index i and sine sign s as follows:
- 0..89: i = a, s = +
- 90..179: i = 180-a, s = +
- 180..269: i = a-180, s = -
- 270..359: i = 360-a, s = -
REQ-022 The cosine index SHALL be 90-i; the cosine sign SHALL be - for 90 < a < 270 and + otherwise.
REQ-023 The quarter-wave ROM SHALL have 91 entries, where entry k = round(sin(k°)*2^(AMP_W-2)), computed at elaboration, with entry 90 = 2^(AMP_W-2) exactly.
REQ-024 Negation SHALL be true two's complement (0 - x), so a zero magnitude always yields 0.
REQ-025 For a >= 360, err_out SHALL be 1 with that result, sin_out = cos_out = 0, and the tag SHALL still be forwarded.
REQ-026 tag_out SHALL be tag_in delayed through the same pipeline, so each tag stays aligned with its result.

Reset
REQ-027 On a clock edge with rst_in = 1, all stage valid bits and out_valid SHALL clear, and sin_out, cos_out, tag_out and err_out SHALL become 0.
REQ-028 Reset SHALL take priority over acceptance, and in-flight samples SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With SINCOS_COS_EN defined, the cosine path (second ROM read port, cosine sign logic) SHALL be built.
REQ-031 Without SINCOS_COS_EN, cos_out SHALL be constant 0, the second ROM port SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Package sincos_pkg SHALL hold:
- the quadrant enum (Q0..Q3)
- localparam LUT_DEPTH = 91
- localparam ANGLE_MAX = 360
- the full-scale function of AMP_W
REQ-033 Sub-module quarter_sine_rom SHALL be a synchronous ROM with 1-cycle read, parameterised by AMP_W, with one read port or two (the second under SINCOS_COS_EN).

Verification (AMP_W=18, full scale 65536)
REQ-034 The bench SHALL cover this scenario: angle 30, tag 3 -> 3 cycles later sin=32768, cos=56756, tag_out=3, err=0.
REQ-035 The bench SHALL cover this scenario: angles 90, 180, 270 back-to-back with out_ready=1 -> in order on consecutive cycles (sin, cos) = (65536, 0), (0, -65536), (-65536, 0).
REQ-036 The bench SHALL cover this scenario: angle 210 -> sin=-32768, cos=-56756.
REQ-037 The bench SHALL cover this scenario: angle 360, then 511 -> err=1, sin=cos=0 each, tags preserved.
REQ-038 The bench SHALL cover this scenario: a stream of 10 angles with out_ready low for 4 cycles mid-stream -> in_ready low during the stall, outputs held, all 10 results in order, none lost.
REQ-039 The bench SHALL cover this scenario: rst_in pulsed with 2 samples in flight -> no out_valid after reset until new input, all outputs 0.
